// File: rtl/decay_timestep_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : decay_timestep_scheduler
// Description : Issues one decay request per neuron each SNN timestep over a
//               shared decay datapath, counts completions and flags misuse.
// Revision    : 1.0 - initial release
// ============================================================================
module decay_timestep_scheduler #(
    parameter int NUM_NEURONS = 10,
    parameter int ADDR_W      = 12,
    parameter int BASE_ADDR   = 0,
    parameter int RATE_W      = 5,
    parameter int TS_W        = 16
) (
    input  logic              CLK,
    input  logic              RESETn,
    input  logic              start_timestep,
    input  logic              cfg_rate_we,
    input  logic [RATE_W-1:0] cfg_rate,
    output logic              clear,
    output logic [RATE_W-1:0] decay_rate,
    output logic              dec_req_valid,
    output logic [ADDR_W-1:0] dec_req_addr,
    input  logic              dec_req_ready,
    input  logic              dec_resp_valid,
    output logic              busy,
    output logic              timestep_done,
    output logic [TS_W-1:0]   timestep_count,
    output logic              overrun,
    output logic              resp_err
);

    localparam int CNT_W = $clog2(NUM_NEURONS + 1);
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(NUM_NEURONS - 1);
    localparam logic [CNT_W-1:0] C_NUM  = CNT_W'(NUM_NEURONS);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_ISSUE = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [RATE_W-1:0]  r_pend_rate;
    logic [RATE_W-1:0]  r_decay_rate;
    logic [CNT_W-1:0]   r_idx;
    logic [CNT_W-1:0]   r_resp_cnt;
    logic [CNT_W-1:0]   w_resp_cnt_nxt;
    logic [TS_W-1:0]    r_ts_count;
    logic               r_overrun;
    logic               r_resp_err;
    logic               w_hs;
    logic               w_resp_ok;
    logic               w_counting;

    assign w_hs       = (r_state == ST_ISSUE) && dec_req_ready;
    assign w_counting = (r_state == ST_ISSUE) || (r_state == ST_DRAIN);
    // r_idx equals requests issued, so r_idx != r_resp_cnt means one is outstanding
    assign w_resp_ok  = dec_resp_valid && w_counting && (r_idx != r_resp_cnt);
    assign w_resp_cnt_nxt = w_resp_ok ? (r_resp_cnt + CNT_W'(1)) : r_resp_cnt;

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  if (start_timestep) w_next = ST_CLEAR;
            ST_CLEAR: w_next = ST_ISSUE;
            ST_ISSUE: if (w_hs && (r_idx == C_LAST)) w_next = ST_DRAIN;
            // Looks at this cycle's response so the final completion reaches DONE next edge
            ST_DRAIN: if (w_resp_cnt_nxt == C_NUM) w_next = ST_DONE;
            ST_DONE:  w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            r_state      <= ST_IDLE;
            r_pend_rate  <= '0;
            r_decay_rate <= '0;
            r_idx        <= '0;
            r_resp_cnt   <= '0;
            r_ts_count   <= '0;
            r_overrun    <= 1'b0;
            r_resp_err   <= 1'b0;
        end else begin
            r_state <= w_next;
            if (cfg_rate_we) begin
                r_pend_rate <= cfg_rate;
            end
            if (r_state == ST_CLEAR) begin
                r_decay_rate <= r_pend_rate;
            end
            if ((r_state == ST_CLEAR) || (r_state == ST_DONE)) begin
                r_idx <= '0;
            end else if (w_hs) begin
                r_idx <= r_idx + CNT_W'(1);
            end
            if (r_state == ST_CLEAR) begin
                r_resp_cnt <= '0;
            end else begin
                r_resp_cnt <= w_resp_cnt_nxt;
            end
            if (r_state == ST_DONE) begin
                r_ts_count <= r_ts_count + TS_W'(1);
            end
            if (start_timestep && (r_state != ST_IDLE)) begin
                r_overrun <= 1'b1;
            end
            if (dec_resp_valid && !w_resp_ok) begin
                r_resp_err <= 1'b1;
            end
        end
    end

    assign clear          = (r_state == ST_CLEAR);
    assign dec_req_valid  = (r_state == ST_ISSUE);
    assign dec_req_addr   = ADDR_W'(BASE_ADDR) + ADDR_W'(r_idx);
    assign busy           = (r_state != ST_IDLE);
    assign timestep_done  = (r_state == ST_DONE);
    assign decay_rate     = r_decay_rate;
    assign timestep_count = r_ts_count;
    assign overrun        = r_overrun;
    assign resp_err       = r_resp_err;

endmodule
`default_nettype wire
